mem_interface: RTL

Memory-side register pair (MAR + MDR) and request sequencer for the datapath. It produces the MDR word the bus mux drives onto the bus and captures bus values into MAR/MDR. It also runs the read/write handshake with the external word-addressed RAM, so the control unit sees a single command pulse and a completion pulse.

---
 rtl/mem_if_pkg.sv | 23 ++
 rtl/mem_timeout_counter.sv | 34 +++
 rtl/mem_interface.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory-side MAR/MDR block and its request sequencer.
// The timeout constants only exist when MEM_TIMEOUT_EN is defined.
package mem_if_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned DEF_TIMEOUT = 15;

    // Counter width able to hold 0..lim.
    function automatic int unsigned cnt_width(input int unsigned lim);
        return (lim < 2) ? 1 : $clog2(lim + 1);
    endfunction
`endif

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request; only built with MEM_TIMEOUT_EN.
// Cleared on request start, counts cycles without ack, saturates at TIMEOUT.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run && (cnt != CNT_W'(TIMEOUT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High during the TIMEOUT-th waiting cycle, so the request gives up on that edge.
    assign expired_c = (cnt >= CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_interface.sv
// MAR/MDR register pair plus a single-outstanding read/write sequencer for a word-addressed RAM.
// Optional request timeout with Err pulse when MEM_TIMEOUT_EN is defined.
module mem_interface
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
`ifdef MEM_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMux_Out,
    input  logic              MAR_In,
    input  logic              MDR_In,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] BusMux_In_MDR,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;

`ifdef MEM_TIMEOUT_EN
    logic expired_c;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clock),
        .rst_n     (clear),
        .start     ((state == IDLE) && (Read || Write)),
        .run       ((state == REQ) && !mem_ack),
        .expired_c (expired_c)
    );
`else
    assign Err = 1'b0;
`endif

    // Sequencer and register file; loads are only honoured in IDLE so the request sees stable MAR/MDR.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            Err     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            Err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (MAR_In) mar <= BusMux_Out[ADDR_W-1:0];
                    if (MDR_In) mdr <= BusMux_Out;
                    // Read has priority when both commands arrive together.
                    if (Read || Write) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        mem_we  <= !Read;
                        Busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        Done    <= 1'b1;
                        if (!mem_we) mdr <= mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (expired_c) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        Busy    <= 1'b0;
                        Err     <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr      = mar;
    assign mem_wdata     = mdr;
    assign BusMux_In_MDR = mdr;

endmodule
